frost_dkg_exchange: RTL and testbench

//  Broadcast/point-to-point mailbox between the frost_node_fsm instances of one DKG session.

---
 rtl/frost_pkg.sv | 34 +++
 rtl/frost_xchg_mask.sv | 45 ++++
 rtl/frost_dkg_exchange.sv | 213 +++++++++++++++++++++
 tb/tb_frost_dkg_exchange.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frost_pkg.sv
// Shared definitions for the FROST DKG exchange: default field widths, phase
// and error encodings, write kinds and the write-rejection priority rule.
package frost_pkg;

  localparam int FROST_SCALAR_BITS = 252;
  localparam int FROST_POINT_BITS  = 255;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_COMMIT   = 2'd1,
    PH_SHARE    = 2'd2,
    PH_COMPLETE = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_PHASE = 2'd1,
    ERR_DUP   = 2'd2,
    ERR_INDEX = 2'd3
  } err_e;

  localparam logic WR_COMMIT = 1'b0;
  localparam logic WR_SHARE  = 1'b1;

  // Rejection causes are checked in priority order; the first one that applies wins.
  function automatic err_e classify_write(input logic idx_ok, input logic kind_ok,
                                          input logic slot_busy);
    if (!idx_ok)       return ERR_INDEX;
    else if (!kind_ok) return ERR_PHASE;
    else if (slot_busy) return ERR_DUP;
    else               return ERR_NONE;
  endfunction

endpackage

// File: rtl/frost_xchg_mask.sv
// Valid-bit bookkeeping for the exchange: commitment mask, per-receiver share
// rows, and the AND-reductions that report complete rows and phases.
module frost_xchg_mask #(
  parameter int NUM_NODES = 4,
  parameter int NW        = 2,
  parameter int SLOT_W    = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  input  logic                           set_commit_i,
  input  logic [NW-1:0]                  commit_idx_i,
  input  logic                           set_share_i,
  input  logic [SLOT_W-1:0]              share_slot_i,
  output logic [NUM_NODES-1:0]           commit_valid_o,
  output logic [NUM_NODES-1:0]           share_valid_o,
  output logic [NUM_NODES*NUM_NODES-1:0] rows_o,
  output logic                           commit_all_o,
  output logic                           share_all_o
);

  logic [NUM_NODES-1:0]           commit_q;
  logic [NUM_NODES*NUM_NODES-1:0] rows_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      commit_q <= '0;
      rows_q   <= '0;
    end else begin
      if (set_commit_i) commit_q[commit_idx_i] <= 1'b1;
      if (set_share_i)  rows_q[share_slot_i]   <= 1'b1;
    end
  end

  // Row i holds the senders whose share for receiver i has arrived.
  for (genvar i = 0; i < NUM_NODES; i++) begin : g_row
    assign share_valid_o[i] = &rows_q[i*NUM_NODES +: NUM_NODES];
  end

  assign commit_valid_o = commit_q;
  assign rows_o         = rows_q;
  assign commit_all_o   = &commit_q;
  assign share_all_o    = &share_valid_o;

endmodule

// File: rtl/frost_dkg_exchange.sv
// DKG mailbox between the node FSMs of one FROST session: collects commitments
// with proofs, then pairwise shares, tracks completion and serves a read port.
module frost_dkg_exchange
  import frost_pkg::*;
#(
  parameter int NUM_NODES   = 4,
  parameter int SCALAR_BITS = FROST_SCALAR_BITS,
  parameter int POINT_BITS  = FROST_POINT_BITS,
  parameter int IDX_W       = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic                   wr_kind_i,
  input  logic [IDX_W-1:0]       wr_src_i,
  input  logic [IDX_W-1:0]       wr_dst_i,
  input  logic [POINT_BITS-1:0]  wr_x_i,
  input  logic [POINT_BITS-1:0]  wr_y_i,
  input  logic [POINT_BITS-1:0]  wr_rx_i,
  input  logic [POINT_BITS-1:0]  wr_ry_i,
  input  logic [SCALAR_BITS-1:0] wr_z_i,
  input  logic                   rd_en_i,
  input  logic                   rd_kind_i,
  input  logic [IDX_W-1:0]       rd_src_i,
  input  logic [IDX_W-1:0]       rd_dst_i,
  output logic                   rd_valid_o,
  output logic [POINT_BITS-1:0]  rd_x_o,
  output logic [POINT_BITS-1:0]  rd_y_o,
  output logic [POINT_BITS-1:0]  rd_rx_o,
  output logic [POINT_BITS-1:0]  rd_ry_o,
  output logic [SCALAR_BITS-1:0] rd_z_o,
  output logic [NUM_NODES-1:0]   commit_valid_o,
  output logic [NUM_NODES-1:0]   share_valid_o,
  output logic [1:0]             phase_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [1:0]             err_code_o
);

  localparam int NW     = $clog2(NUM_NODES);
  localparam int SLOTS  = NUM_NODES * NUM_NODES;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam logic [IDX_W:0] NODES_L = (IDX_W + 1)'(NUM_NODES);

  function automatic logic [SLOT_W-1:0] slot_of(input logic [NW-1:0] dst,
                                                input logic [NW-1:0] src);
    return SLOT_W'(int'(dst) * NUM_NODES + int'(src));
  endfunction

  phase_e phase_q;
  err_e   err_code_q, wr_code;
  logic   done_q, err_q;

  logic [NUM_NODES-1:0] commit_valid, share_valid;
  logic [SLOTS-1:0]     rows;
  logic                 commit_all, share_all;

  logic [NW-1:0]     wr_src_n, wr_dst_n, rd_src_n, rd_dst_n;
  logic [SLOT_W-1:0] wr_slot, rd_slot;
  logic wr_src_ok, wr_dst_ok, wr_idx_ok, wr_kind_ok, wr_busy, wr_acc;
  logic store_commit, store_share, rd_src_ok, rd_dst_ok;

  logic [POINT_BITS-1:0]  c_x_q [NUM_NODES];
  logic [POINT_BITS-1:0]  c_y_q [NUM_NODES];
  logic [POINT_BITS-1:0]  c_rx_q[NUM_NODES];
  logic [POINT_BITS-1:0]  c_ry_q[NUM_NODES];
  logic [SCALAR_BITS-1:0] c_z_q [NUM_NODES];
  logic [SCALAR_BITS-1:0] sh_q  [SLOTS];

  logic                   rd_valid_q;
  logic [POINT_BITS-1:0]  rd_x_q, rd_y_q, rd_rx_q, rd_ry_q;
  logic [POINT_BITS-1:0]  rd_x_d, rd_y_d, rd_rx_d, rd_ry_d;
  logic [SCALAR_BITS-1:0] rd_z_q, rd_z_d;

  assign wr_ready_o = (phase_q == PH_COMMIT || phase_q == PH_SHARE) && !err_q;

  // A start in the same cycle takes priority and discards any write.
  always_comb begin
    wr_src_n   = wr_src_i[NW-1:0];
    wr_dst_n   = wr_dst_i[NW-1:0];
    wr_slot    = slot_of(wr_dst_n, wr_src_n);
    wr_src_ok  = {1'b0, wr_src_i} < NODES_L;
    wr_dst_ok  = {1'b0, wr_dst_i} < NODES_L;
    wr_idx_ok  = wr_src_ok && (wr_kind_i == WR_COMMIT || wr_dst_ok);
    wr_kind_ok = wr_kind_i == ((phase_q == PH_COMMIT) ? WR_COMMIT : WR_SHARE);
    wr_busy    = (wr_kind_i == WR_COMMIT) ? commit_valid[wr_src_n] : rows[wr_slot];
    wr_code    = classify_write(wr_idx_ok, wr_kind_ok, wr_busy);
    wr_acc     = wr_valid_i && wr_ready_o && !start_i;
    store_commit = wr_acc && (wr_code == ERR_NONE) && (wr_kind_i == WR_COMMIT);
    store_share  = wr_acc && (wr_code == ERR_NONE) && (wr_kind_i == WR_SHARE);
  end

  frost_xchg_mask #(
    .NUM_NODES (NUM_NODES),
    .NW        (NW),
    .SLOT_W    (SLOT_W)
  ) u_mask (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (start_i),
    .set_commit_i   (store_commit),
    .commit_idx_i   (wr_src_n),
    .set_share_i    (store_share),
    .share_slot_i   (wr_slot),
    .commit_valid_o (commit_valid),
    .share_valid_o  (share_valid),
    .rows_o         (rows),
    .commit_all_o   (commit_all),
    .share_all_o    (share_all)
  );

  // Phases advance on the registered masks, one cycle after the last bit lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q    <= PH_IDLE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (start_i) begin
      phase_q    <= PH_COMMIT;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      if (wr_acc && wr_code != ERR_NONE) begin
        err_q      <= 1'b1;
        err_code_q <= wr_code;
      end
      case (phase_q)
        PH_COMMIT: if (commit_all) phase_q <= PH_SHARE;
        PH_SHARE: begin
          if (share_all) begin
            phase_q <= PH_COMPLETE;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (store_commit) begin
      c_x_q[wr_src_n]  <= wr_x_i;
      c_y_q[wr_src_n]  <= wr_y_i;
      c_rx_q[wr_src_n] <= wr_rx_i;
      c_ry_q[wr_src_n] <= wr_ry_i;
      c_z_q[wr_src_n]  <= wr_z_i;
    end
    if (store_share) sh_q[wr_slot] <= wr_x_i[SCALAR_BITS-1:0];
  end

  always_comb begin
    rd_src_n  = rd_src_i[NW-1:0];
    rd_dst_n  = rd_dst_i[NW-1:0];
    rd_slot   = slot_of(rd_dst_n, rd_src_n);
    rd_src_ok = {1'b0, rd_src_i} < NODES_L;
    rd_dst_ok = {1'b0, rd_dst_i} < NODES_L;
    rd_x_d  = '0;
    rd_y_d  = '0;
    rd_rx_d = '0;
    rd_ry_d = '0;
    rd_z_d  = '0;
    if (rd_kind_i == WR_COMMIT) begin
      if (rd_src_ok) begin
        rd_x_d  = c_x_q[rd_src_n];
        rd_y_d  = c_y_q[rd_src_n];
        rd_rx_d = c_rx_q[rd_src_n];
        rd_ry_d = c_ry_q[rd_src_n];
        rd_z_d  = c_z_q[rd_src_n];
      end
    end else if (rd_src_ok && rd_dst_ok) begin
      rd_x_d = POINT_BITS'(sh_q[rd_slot]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_rx_q    <= '0;
      rd_ry_q    <= '0;
      rd_z_q     <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_x_q  <= rd_x_d;
        rd_y_q  <= rd_y_d;
        rd_rx_q <= rd_rx_d;
        rd_ry_q <= rd_ry_d;
        rd_z_q  <= rd_z_d;
      end
    end
  end

  assign rd_valid_o     = rd_valid_q;
  assign rd_x_o         = rd_x_q;
  assign rd_y_o         = rd_y_q;
  assign rd_rx_o        = rd_rx_q;
  assign rd_ry_o        = rd_ry_q;
  assign rd_z_o         = rd_z_q;
  assign commit_valid_o = commit_valid;
  assign share_valid_o  = share_valid;
  assign phase_o        = phase_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign err_code_o     = err_code_q;

endmodule

// File: tb/tb_frost_dkg_exchange.sv
// Bench for frost_dkg_exchange: directed protocol scenarios plus randomized
// sessions, all checked every cycle against a behavioural mailbox model.
module tb_frost_dkg_exchange;

  localparam int N  = 4;
  localparam int SB = 252;
  localparam int PB = 255;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0;
  logic wr_valid = 1'b0, wr_kind = 1'b0, rd_en = 1'b0, rd_kind = 1'b0;
  logic [IW-1:0] wr_src = '0, wr_dst = '0, rd_src = '0, rd_dst = '0;
  logic [PB-1:0] wr_x = '0, wr_y = '0, wr_rx = '0, wr_ry = '0;
  logic [SB-1:0] wr_z = '0;
  logic wr_ready, rd_valid, done, err;
  logic [PB-1:0] rd_x, rd_y, rd_rx, rd_ry;
  logic [SB-1:0] rd_z;
  logic [N-1:0]  commit_valid, share_valid;
  logic [1:0]    phase, err_code;

  always #5 clk = ~clk;

  frost_dkg_exchange #(.NUM_NODES(N), .SCALAR_BITS(SB), .POINT_BITS(PB), .IDX_W(IW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_kind_i(wr_kind),
    .wr_src_i(wr_src), .wr_dst_i(wr_dst),
    .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_rx_i(wr_rx), .wr_ry_i(wr_ry), .wr_z_i(wr_z),
    .rd_en_i(rd_en), .rd_kind_i(rd_kind), .rd_src_i(rd_src), .rd_dst_i(rd_dst),
    .rd_valid_o(rd_valid), .rd_x_o(rd_x), .rd_y_o(rd_y), .rd_rx_o(rd_rx),
    .rd_ry_o(rd_ry), .rd_z_o(rd_z),
    .commit_valid_o(commit_valid), .share_valid_o(share_valid),
    .phase_o(phase), .done_o(done), .err_o(err), .err_code_o(err_code)
  );

  int checks = 0, errors = 0, n_done = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- behavioural model ----------------
  bit m_init = 0;
  int m_phase, m_code;
  bit m_err, m_done;
  bit m_cv[N];
  bit m_sv[N][N];
  logic [PB-1:0] m_cx[N], m_cy[N], m_crx[N], m_cry[N];
  logic [SB-1:0] m_cz[N];
  bit m_ck[N];
  logic [SB-1:0] m_sh[N][N];
  bit m_shk[N][N];
  bit m_rdv, m_rdk;
  logic [PB-1:0] m_rx, m_ry, m_rrx, m_rry;
  logic [SB-1:0] m_rz;

  function automatic logic [N-1:0] cv_vec();
    logic [N-1:0] v;
    for (int j = 0; j < N; j++) v[j] = m_cv[j];
    return v;
  endfunction

  function automatic logic [N-1:0] sv_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1;
      for (int j = 0; j < N; j++) if (!m_sv[i][j]) v[i] = 1'b0;
    end
    return v;
  endfunction

  function automatic bit m_ready();
    return (m_phase == 1 || m_phase == 2) && !m_err;
  endfunction

  always @(posedge clk) begin : model
    int s, d, code;
    bit all_c, all_s;
    if (rst) begin
      m_init = 1; m_phase = 0; m_code = 0; m_err = 0; m_done = 0;
      m_rdv = 0; m_rdk = 1; m_rx = '0; m_ry = '0; m_rrx = '0; m_rry = '0; m_rz = '0;
      for (int i = 0; i < N; i++) begin
        m_cv[i] = 0;
        for (int j = 0; j < N; j++) m_sv[i][j] = 0;
      end
    end else begin
      m_rdv = rd_en;
      if (rd_en) begin
        s = int'(rd_src); d = int'(rd_dst);
        m_rdk = 1; m_rx = '0; m_ry = '0; m_rrx = '0; m_rry = '0; m_rz = '0;
        if (!rd_kind) begin
          if (s < N) begin
            m_rdk = m_ck[s];
            m_rx = m_cx[s]; m_ry = m_cy[s]; m_rrx = m_crx[s]; m_rry = m_cry[s]; m_rz = m_cz[s];
          end
        end else if (s < N && d < N) begin
          m_rdk = m_shk[d][s];
          m_rx = PB'(m_sh[d][s]);
        end
      end
      if (start) begin
        m_phase = 1; m_err = 0; m_code = 0; m_done = 0;
        for (int i = 0; i < N; i++) begin
          m_cv[i] = 0;
          for (int j = 0; j < N; j++) m_sv[i][j] = 0;
        end
      end else begin
        all_c = (cv_vec() == '1);
        all_s = (sv_vec() == '1);
        m_done = 0;
        if (wr_valid && m_ready()) begin
          s = int'(wr_src); d = int'(wr_dst);
          if (s >= N || (wr_kind && d >= N)) code = 3;
          else if (wr_kind != (m_phase == 2)) code = 1;
          else if (wr_kind ? m_sv[d][s] : m_cv[s]) code = 2;
          else code = 0;
          if (code != 0) begin
            m_err = 1; m_code = code;
          end else if (!wr_kind) begin
            m_cv[s] = 1; m_ck[s] = 1;
            m_cx[s] = wr_x; m_cy[s] = wr_y; m_crx[s] = wr_rx; m_cry[s] = wr_ry; m_cz[s] = wr_z;
          end else begin
            m_sv[d][s] = 1; m_shk[d][s] = 1; m_sh[d][s] = wr_x[SB-1:0];
          end
        end
        if (m_phase == 1 && all_c) m_phase = 2;
        else if (m_phase == 2 && all_s) begin
          m_phase = 3; m_done = 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_init && !rst) begin
      chk("phase", phase, m_phase);
      chk("commit_valid", commit_valid, cv_vec());
      chk("share_valid", share_valid, sv_vec());
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("err_code", err_code, m_code);
      chk("wr_ready", wr_ready, m_ready());
      chk("rd_valid", rd_valid, m_rdv);
      if (m_rdv && m_rdk) begin
        chk("rd_x", rd_x, m_rx);
        chk("rd_y", rd_y, m_ry);
        chk("rd_rx", rd_rx, m_rrx);
        chk("rd_ry", rd_ry, m_rry);
        chk("rd_z", rd_z, m_rz);
      end
      if (done) n_done++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    wr_valid = 0; start = 0; rd_en = 0;
  endtask

  task automatic do_start();
    start = 1;
    step();
  endtask

  task automatic put_commit(input int src, input logic [PB-1:0] x);
    wr_valid = 1; wr_kind = 0; wr_src = IW'(src); wr_dst = IW'($urandom_range(15));
    wr_x = x; wr_y = PB'(rnd256()); wr_rx = PB'(rnd256()); wr_ry = PB'(rnd256());
    wr_z = SB'(rnd256());
  endtask

  task automatic put_share(input int src, input int dst, input logic [PB-1:0] x);
    wr_valid = 1; wr_kind = 1; wr_src = IW'(src); wr_dst = IW'(dst); wr_x = x;
    wr_y = PB'(rnd256()); wr_rx = PB'(rnd256()); wr_ry = PB'(rnd256()); wr_z = SB'(rnd256());
  endtask

  task automatic put_read(input bit k, input int src, input int dst);
    rd_en = 1; rd_kind = k; rd_src = IW'(src); rd_dst = IW'(dst);
  endtask

  task automatic commit_all();
    for (int s = 0; s < N; s++) begin
      put_commit(s, PB'(rnd256()));
      step();
    end
    step();
  endtask

  initial begin
    int q[$];
    int a, src, dst, r;
    bit k;

    repeat (3) @(negedge clk);
    chk("rst_phase", phase, 2'd0);
    chk("rst_masks", {commit_valid, share_valid}, '0);
    chk("rst_flags", {done, err, err_code, rd_valid, wr_ready}, '0);
    chk("rst_rd_data", {rd_x, rd_z}, '0);
    rst = 0;

    // Commitment round
    do_start();
    chk("t1_phase_commit", phase, 2'd1);
    for (int s = 0; s < N; s++) begin
      put_commit(s, PB'(rnd256()));
      step();
      chk("t1_commit_valid", commit_valid, (4'b1 << (s + 1)) - 4'b1);
    end
    chk("t1_still_commit", phase, 2'd1);
    step();
    chk("t1_phase_share", phase, 2'd2);
    chk("t1_model_phase", m_phase, 2);

    // Share round, s_{j->i} = 16*j + i
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        put_share(j, i, PB'(16 * j + i));
        step();
      end
      chk("t2_share_valid", share_valid, (4'b1 << (i + 1)) - 4'b1);
    end
    chk("t2_no_done_yet", {phase, done}, {2'd2, 1'b0});
    step();
    chk("t2_complete", {phase, done}, {2'd3, 1'b1});
    step();
    chk("t2_done_pulse", {phase, done}, {2'd3, 1'b0});
    chk("t2_done_once", n_done, 1);
    put_read(1, 2, 1);
    step();
    chk("t2_read_valid", rd_valid, 1'b1);
    chk("t2_read_share", rd_x, 255'h21);
    chk("t2_read_other", {rd_y, rd_z}, '0);
    chk("t2_model_read", m_rx, 255'h21);
    for (int n = 0; n < 12; n++) begin
      put_read($urandom_range(1), $urandom_range(5), $urandom_range(5));
      step();
    end

    // Commitment during SHARE
    do_start();
    commit_all();
    put_commit(0, PB'(rnd256()));
    step();
    chk("t3_err", {err, err_code, wr_ready}, {1'b1, 2'd1, 1'b0});
    chk("t3_masks", {commit_valid, share_valid}, {4'b1111, 4'b0000});

    // Duplicate, then out-of-range index
    do_start();
    put_commit(1, PB'(rnd256()));
    step();
    put_commit(1, PB'(rnd256()));
    step();
    chk("t4_dup", {err, err_code}, {1'b1, 2'd2});
    do_start();
    chk("t4_cleared", {err, err_code}, 3'b000);
    put_commit(5, PB'(rnd256()));
    step();
    chk("t4_index", {err, err_code}, {1'b1, 2'd3});

    // Same-cycle read and write of one slot returns the old data
    do_start();
    put_commit(3, 255'hAA);
    step();
    do_start();
    put_commit(3, 255'hBB);
    put_read(0, 3, 0);
    step();
    chk("t5_old", rd_x, 255'hAA);
    put_read(0, 3, 0);
    step();
    chk("t5_new", rd_x, 255'hBB);

    // Restart mid-SHARE
    do_start();
    commit_all();
    for (int n = 0; n < 7; n++) begin
      put_share(n % N, n / N, PB'(rnd256()));
      step();
    end
    chk("t6_partial", share_valid, 4'b0001);
    do_start();
    chk("t6_restart", {phase, commit_valid, share_valid, err}, {2'd1, 4'b0, 4'b0, 1'b0});

    // Randomized sessions
    for (int c = 0; c < 3000; c++) begin
      if (((m_err || m_phase == 3 || m_phase == 0) && $urandom_range(3) == 0) ||
          $urandom_range(299) == 0)
        start = 1;
      if ($urandom_range(3) != 0) begin
        k = (m_phase == 2);
        q = {};
        for (int b = 0; b < N * N; b++)
          if (k ? !m_sv[b / N][b % N] : (b < N && !m_cv[b])) q.push_back(b);
        if (q.size() != 0 && $urandom_range(9) != 0) begin
          a = q[$urandom_range(q.size() - 1)];
          if (k) begin dst = a / N; src = a % N; end
          else begin src = a; dst = $urandom_range(15); end
        end else begin
          src = $urandom_range(N - 1); dst = $urandom_range(N - 1);
        end
        r = $urandom_range(59);
        if (r == 0) k = !k;
        if (r == 1) src = $urandom_range(15);
        if (r == 2) dst = $urandom_range(15);
        if (k) put_share(src, dst, PB'(rnd256()));
        else   put_commit(src, PB'(rnd256()));
      end
      if ($urandom_range(1) != 0)
        put_read($urandom_range(1), $urandom_range(5), $urandom_range(5));
      step();
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
